// File: rtl/mx11seq_issue_if.sv
// Front-end instruction handshake between the instruction source and the issue sequencer.
interface mx11seq_issue_if #(
  parameter int unsigned INSTR_W = 17
) ();
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;

  modport master (
    output instr_valid,
    output instr_data,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_data,
    output instr_ready
  );
endinterface

// File: rtl/mx11seq_issue.sv
// MX11 SEU issue sequencer: instruction FIFO plus IDLE/EXEC/WRITE issue FSM.
// Define MX11SEQ_PERF_EN to build the saturating retired/stall performance counters.
module mx11seq_issue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned INSTR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  mx11seq_issue_if.slave        instr_if,
  input  logic                  flush_i,
  input  logic                  hold_i,
  output logic [3:0]            seu_opcode_o,
  output logic [3:0]            seu_src_a_o,
  output logic [3:0]            seu_src_b_o,
  output logic [3:0]            seu_dst_f_o,
  output logic                  seu_fetch_o,
  output logic                  seu_cs_n_o,
  output logic                  reg_we_o,
  output logic                  busy_o,
  output logic                  retire_o,
  output logic [15:0]           perf_retired_o,
  output logic [15:0]           perf_stalls_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StExec, StWrite} state_e;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic               full, empty, pop, push;
  logic [INSTR_W-1:0] head;

  state_e             state_q, state_d;
  logic [3:0]         seu_opcode_q, seu_src_a_q, seu_src_b_q, seu_dst_f_q;
  logic               seu_fetch_q, seu_cs_n_q, reg_we_q, retire_q, busy_q;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // flush blocks both issue and enqueue for the cycle it is high
  assign pop                  = (state_q == StIdle) && !empty && !hold_i && !flush_i;
  assign instr_if.instr_ready = !flush_i && (!full || pop);
  assign push                 = instr_if.instr_valid && instr_if.instr_ready;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= instr_if.instr_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (pop) state_d = StExec;
      StExec:  state_d = flush_i ? StIdle : StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // WRITE is the commit point: a flush seen in EXEC suppresses the write, one seen in WRITE does not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      seu_opcode_q <= '0;
      seu_src_a_q  <= '0;
      seu_src_b_q  <= '0;
      seu_dst_f_q  <= '0;
      seu_fetch_q  <= 1'b0;
      seu_cs_n_q   <= 1'b1;
      reg_we_q     <= 1'b0;
      retire_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != StIdle) || (count_d != '0);
      reg_we_q <= (state_q == StExec) && !flush_i;
      retire_q <= (state_q == StExec) && !flush_i;
      if (pop) begin
        {seu_fetch_q, seu_opcode_q, seu_src_a_q, seu_src_b_q, seu_dst_f_q} <= head[16:0];
        seu_cs_n_q <= 1'b0;
      end else if (state_d == StIdle) begin
        seu_cs_n_q <= 1'b1;
      end
    end
  end

  assign seu_opcode_o = seu_opcode_q;
  assign seu_src_a_o  = seu_src_a_q;
  assign seu_src_b_o  = seu_src_b_q;
  assign seu_dst_f_o  = seu_dst_f_q;
  assign seu_fetch_o  = seu_fetch_q;
  assign seu_cs_n_o   = seu_cs_n_q;
  assign reg_we_o     = reg_we_q;
  assign retire_o     = retire_q;
  assign busy_o       = busy_q;

`ifdef MX11SEQ_PERF_EN
  logic [15:0] perf_retired_q, perf_stalls_q;
  logic        retire_d, stall;

  assign retire_d = (state_q == StExec) && !flush_i;
  assign stall    = (state_q == StIdle) && !empty && hold_i;

  // saturating; only rst clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      if (retire_d && (perf_retired_q != 16'hFFFF)) perf_retired_q <= perf_retired_q + 16'd1;
      if (stall && (perf_stalls_q != 16'hFFFF))     perf_stalls_q  <= perf_stalls_q + 16'd1;
    end
  end

  assign perf_retired_o = perf_retired_q;
  assign perf_stalls_o  = perf_stalls_q;
`else
  assign perf_retired_o = 16'h0;
  assign perf_stalls_o  = 16'h0;
`endif

endmodule

// File: tb/tb_mx11seq_issue.sv
// Randomized scoreboard bench for mx11seq_issue against a queue-based issue model.
module tb_mx11seq_issue;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned INSTR_W = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, hold;
  logic [3:0]  seu_opcode, seu_src_a, seu_src_b, seu_dst_f;
  logic        seu_fetch, seu_cs_n, reg_we, busy, retire;
  logic [15:0] perf_retired, perf_stalls;

  int n_vec = 0;
  int n_err = 0;

  mx11seq_issue_if #(.INSTR_W(INSTR_W)) u_if ();

  mx11seq_issue #(.DEPTH(DEPTH), .INSTR_W(INSTR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_if       (u_if),
    .flush_i        (flush),
    .hold_i         (hold),
    .seu_opcode_o   (seu_opcode),
    .seu_src_a_o    (seu_src_a),
    .seu_src_b_o    (seu_src_b),
    .seu_dst_f_o    (seu_dst_f),
    .seu_fetch_o    (seu_fetch),
    .seu_cs_n_o     (seu_cs_n),
    .reg_we_o       (reg_we),
    .busy_o         (busy),
    .retire_o       (retire),
    .perf_retired_o (perf_retired),
    .perf_stalls_o  (perf_stalls)
  );

  always #5 clk = ~clk;

  // Reference model: accepted instructions wait in m_q; an issued op is 1 cycle in
  // execution (stage 1) then 1 cycle writing (stage 2). exp_q is the scoreboard.
  logic [16:0] m_q[$];
  logic [16:0] exp_q[$];
  int          m_stage;
  logic [16:0] m_cur;
  logic        m_cs_n, m_we;
  int          m_ret, m_stl;

  function automatic logic m_pop_now();
    return (m_stage == 0) && (m_q.size() != 0) && !hold && !flush;
  endfunction

  function automatic logic m_ready_now();
    return !flush && ((m_q.size() < int'(DEPTH)) || m_pop_now());
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    logic pop, push;
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_stage = 0;
      m_cur   = '0;
      m_cs_n  = 1'b1;
      m_we    = 1'b0;
      m_ret   = 0;
      m_stl   = 0;
    end else begin
      pop  = m_pop_now();
      push = u_if.instr_valid && m_ready_now();
      if ((m_stage == 0) && (m_q.size() != 0) && hold && (m_stl < 65535)) m_stl++;
      m_we = 1'b0;
      case (m_stage)
        0: if (pop) begin
          m_cur   = m_q.pop_front();
          m_cs_n  = 1'b0;
          m_stage = 1;
        end
        1: if (flush) begin
          m_stage = 0;
          m_cs_n  = 1'b1;
        end else begin
          m_stage = 2;
          m_we    = 1'b1;
          exp_q.push_back(m_cur);
          if (m_ret < 65535) m_ret++;
        end
        default: begin
          m_stage = 0;
          m_cs_n  = 1'b1;
        end
      endcase
      if (flush) m_q.delete();
      else if (push) m_q.push_back(u_if.instr_data);
    end
  end

  always @(negedge clk) begin : monitor
    logic [16:0] e;
    chk("instr_ready", 32'(u_if.instr_ready), 32'(m_ready_now()));
    chk("seu_cs_n", 32'(seu_cs_n), 32'(m_cs_n));
    chk("reg_we", 32'(reg_we), 32'(m_we));
    chk("retire", 32'(retire), 32'(m_we));
    chk("busy", 32'(busy), 32'((m_stage != 0) || (m_q.size() != 0)));
    chk("seu_fields", 32'({seu_fetch, seu_opcode, seu_src_a, seu_src_b, seu_dst_f}), 32'(m_cur));
    if (reg_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected_write: got reg_we=1 expected no pending op at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_write_fields",
            32'({seu_fetch, seu_opcode, seu_src_a, seu_src_b, seu_dst_f}), 32'(e));
      end
    end
`ifdef MX11SEQ_PERF_EN
    chk("perf_retired", 32'(perf_retired), 32'(m_ret));
    chk("perf_stalls", 32'(perf_stalls), 32'(m_stl));
`else
    chk("perf_retired", 32'(perf_retired), 32'h0);
    chk("perf_stalls", 32'(perf_stalls), 32'h0);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves instr_valid high; caller drops it.
  task automatic push_one(input logic [16:0] d);
    logic acc;
    acc = 1'b0;
    u_if.instr_valid = 1'b1;
    u_if.instr_data  = d;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = m_ready_now();
      tick();
    end
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic wait_stage(input int s);
    int i;
    for (i = 0; i < 50 && m_stage != s; i++) tick();
    if (m_stage != s) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_stage: got stage %0d expected %0d within 50 cycles", m_stage, s);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    hold = 1'b0;
    u_if.instr_valid = 1'b0;
    u_if.instr_data  = '0;
    #1;
    chk("rst_reg_we", 32'(reg_we), 32'h0);
    chk("rst_cs_n", 32'(seu_cs_n), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fields", 32'({seu_fetch, seu_opcode, seu_src_a, seu_src_b, seu_dst_f}), 32'h0);
    chk("rst_ready", 32'(u_if.instr_ready), 32'h1);
    idle(3);
    rst = 1'b0;
    idle(2);

    // single op into an empty FIFO
    push_one({1'b0, 4'h3, 4'h1, 4'h2, 4'h5});
    u_if.instr_valid = 1'b0;
    idle(6);

    // six pushes with valid held; fills the FIFO and pushes at full alongside a pop
    for (int i = 0; i < 6; i++) push_one(17'(32'h1_0000 | (i * 32'h1111)));
    u_if.instr_valid = 1'b0;
    idle(25);

    // flush during EXEC with two queued, then during WRITE
    for (int pass = 0; pass < 2; pass++) begin
      hold = 1'b1;
      for (int i = 0; i < 3; i++) push_one(17'($urandom));
      u_if.instr_valid = 1'b0;
      hold = 1'b0;
      wait_stage(pass + 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("flush_busy", 32'(busy), 32'h0);
      idle(4);
    end

    // hold with one queued op for 10 cycles
    hold = 1'b1;
    push_one(17'h0_0abc);
    u_if.instr_valid = 1'b0;
    idle(10);
    hold = 1'b0;
    idle(6);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      u_if.instr_valid = ($urandom_range(0, 9) < 7);
      u_if.instr_data  = 17'($urandom);
      hold  = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 99) < 3);
      tick();
    end
    u_if.instr_valid = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    idle(20);
    chk("sb_drain", 32'(exp_q.size()), 32'h0);

    // asynchronous reset in the middle of WRITE
    push_one(17'h1_2345);
    u_if.instr_valid = 1'b0;
    wait_stage(2);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_reg_we", 32'(reg_we), 32'h0);
    chk("midrst_retire", 32'(retire), 32'h0);
    chk("midrst_cs_n", 32'(seu_cs_n), 32'h1);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_fields", 32'({seu_fetch, seu_opcode, seu_src_a, seu_src_b, seu_dst_f}), 32'h0);
    chk("midrst_perf", 32'({perf_retired, perf_stalls}), 32'h0);
    tick();
    rst = 1'b0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
